// File: rtl/dm_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped read cache.
package dm_cache_pkg;

  localparam int ADDR_W_D  = 15;
  localparam int INDEX_W_D = 8;
  localparam int OFF_W     = 2;
  localparam int TAG_W     = ADDR_W_D - INDEX_W_D - OFF_W;
  localparam int LINES     = 1 << INDEX_W_D;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT} state_t;

  // Word offset within a 4-word block.
  function automatic logic [OFF_W-1:0] a_off(input logic [31:0] a);
    return a[OFF_W-1:0];
  endfunction

  // Line index; caller truncates to its INDEX_W.
  function automatic logic [31:0] a_idx(input logic [31:0] a, input int iw);
    return (a >> OFF_W) & ((32'd1 << iw) - 32'd1);
  endfunction

  // Tag; caller truncates to its tag width.
  function automatic logic [31:0] a_tag(input logic [31:0] a, input int iw);
    return a >> (iw + OFF_W);
  endfunction

endpackage

// File: rtl/dm_cache_line_store.sv
// Tag/valid/data arrays: combinational read by index, whole-line write.
module dm_cache_line_store #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 5,
  parameter int WORD_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [INDEX_W-1:0]          rd_idx,
  output logic                        rd_vld,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [3:0][WORD_W-1:0]      rd_data,
  input  logic                        wr_en,
  input  logic [INDEX_W-1:0]          wr_idx,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [3:0][WORD_W-1:0]      wr_data
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] vld;
  logic [TAG_W-1:0] tag_arr [LINES];

  // Valid bits are the only cleared state; a cleared line never hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld         <= '0;
    else if (wr_en) vld[wr_idx] <= 1'b1;
  end

  // Tag array, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) tag_arr[wr_idx] <= wr_tag;
  end

  assign rd_vld = vld[rd_idx];
  assign rd_tag = tag_arr[rd_idx];

  // One data bank per word offset, all written together on a fill.
  for (genvar w = 0; w < 4; w++) begin : g_bank
    logic [WORD_W-1:0] bank [LINES];
    always_ff @(posedge clk) begin
      if (wr_en) bank[wr_idx] <= wr_data[w];
    end
    assign rd_data[w] = bank[rd_idx];
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: FSM, address latch, fill timing, counters.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int INDEX_W = 8,
  parameter int WORD_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data0,
  input  logic [WORD_W-1:0] mem_data1,
  input  logic [WORD_W-1:0] mem_data2,
  input  logic [WORD_W-1:0] mem_data3,
  output logic [31:0]       access_cnt,
  output logic [31:0]       hit_cnt
);
  localparam int TW   = ADDR_W - INDEX_W - OFF_W;
  localparam int WC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t                   state;
  logic [ADDR_W-1:0]        areg;
  logic [WC_W-1:0]          wcnt;
  logic [OFF_W-1:0]         off;
  logic [INDEX_W-1:0]       idx;
  logic [TW-1:0]            tag;
  logic                     ln_vld;
  logic [TW-1:0]            ln_tag;
  logic [3:0][WORD_W-1:0]   ln_data;
  logic [3:0][WORD_W-1:0]   mem_words;
  logic                     hit;
  logic                     fill;

  assign off       = a_off(32'(areg));
  assign idx       = INDEX_W'(a_idx(32'(areg), INDEX_W));
  assign tag       = TW'(a_tag(32'(areg), INDEX_W));
  assign mem_words = {mem_data3, mem_data2, mem_data1, mem_data0};
  assign hit       = ln_vld && (ln_tag == tag);
  assign fill      = (state == MEM_WAIT) && (wcnt == '0);
  assign req_ready = (state == IDLE);

  dm_cache_line_store #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TW),
    .WORD_W (WORD_W)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (idx),
    .rd_vld (ln_vld),
    .rd_tag (ln_tag),
    .rd_data(ln_data),
    .wr_en  (fill),
    .wr_idx (idx),
    .wr_tag (tag),
    .wr_data(mem_words)
  );

  // Controller FSM; resp_valid and mem_read default low so each is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      areg       <= '0;
      wcnt       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      access_cnt <= '0;
      hit_cnt    <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            areg       <= req_addr;
            access_cnt <= access_cnt + 32'd1;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data  <= ln_data[off];
            resp_valid <= 1'b1;
            hit_cnt    <= hit_cnt + 32'd1;
            state      <= IDLE;
          end else begin
            // Strobe is raised on entry so it is high exactly while in MEM_REQ.
            mem_read <= 1'b1;
            mem_addr <= {tag, idx, 2'b00};
            state    <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          wcnt  <= WC_W'(MEM_LAT - 1);
          state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else begin
            resp_data  <= mem_words[off];
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
